// File: rtl/tcp_dma_rd_arb.sv
// Round-robin arbiter sharing one AXI-lite read master among NUM_REQ DMA read requesters.
// One transaction in flight at a time; the address toward memory is registered.
module tcp_dma_rd_arb #(
  parameter int NUM_REQ    = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            s_arvalid,
  output logic [NUM_REQ-1:0]            s_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_REQ*3-1:0]          s_arprot,
  output logic [NUM_REQ-1:0]            s_rvalid,
  input  logic [NUM_REQ-1:0]            s_rready,
  output logic [DATA_WIDTH-1:0]         s_rdata,
  output logic [1:0]                    s_rresp,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [2:0]                    m_arprot,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  output logic                          o_busy,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] winner;
  logic          found;

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return GW'(sum);
  endfunction

  // Descending scan so the last hit is the first requester at or after rr_ptr.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (s_arvalid[wrap_idx(rr_ptr, k)]) begin
        found  = 1'b1;
        winner = wrap_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    s_arready = '0;
    s_rvalid  = '0;
    m_rready  = 1'b0;
    s_rdata   = '0;
    s_rresp   = '0;
    case (state)
      IDLE: if (found) s_arready[winner] = 1'b1;
      DATA: begin
        s_rvalid[o_grant] = m_rvalid;
        m_rready          = s_rready[o_grant];
        s_rdata           = m_rdata;
        s_rresp           = m_rresp;
      end
      default: ;
    endcase
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      o_grant   <= '0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arprot  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            m_araddr  <= s_araddr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            m_arprot  <= s_arprot[int'(winner)*3 +: 3];
            m_arvalid <= 1'b1;
            o_grant   <= winner;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          // The just-served requester drops to lowest priority for the next round.
          if (m_rvalid && s_rready[o_grant]) begin
            rr_ptr <= (o_grant == GW'(NUM_REQ - 1)) ? '0 : o_grant + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_dma_rd_arb.sv
// Scoreboard bench for tcp_dma_rd_arb: directed requests with hand-chosen grant order,
// a small memory responder, and a monitor that checks every AR/R handshake against the queue.
module tb_tcp_dma_rd_arb;

  localparam int NUM_REQ = 16;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int GW      = 4;

  logic                   i_clk = 1'b0;
  logic                   i_rst;
  logic [NUM_REQ-1:0]     s_arvalid;
  logic [NUM_REQ-1:0]     s_arready;
  logic [NUM_REQ*AW-1:0]  s_araddr;
  logic [NUM_REQ*3-1:0]   s_arprot;
  logic [NUM_REQ-1:0]     s_rvalid;
  logic [NUM_REQ-1:0]     s_rready;
  logic [DW-1:0]          s_rdata;
  logic [1:0]             s_rresp;
  logic [AW-1:0]          m_araddr;
  logic [2:0]             m_arprot;
  logic                   m_arvalid;
  logic                   m_arready;
  logic [DW-1:0]          m_rdata;
  logic [1:0]             m_rresp;
  logic                   m_rvalid;
  logic                   m_rready;
  logic                   o_busy;
  logic [GW-1:0]          o_grant;

  tcp_dma_rd_arb #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .o_busy(o_busy), .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          req;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          issued[NUM_REQ];
  int          accepted[NUM_REQ];
  int          ar_wait;
  int          r_wait;
  logic        mem_fix;
  logic [31:0] mem_fix_data;
  logic [1:0]  mem_resp;

  function automatic logic [31:0] reqAddr(input int i);
    return (i == 3) ? 32'h1000_0040 : 32'h2000_0000 + 32'(i) * 32'h100;
  endfunction

  // The memory responder returns the inverted address unless a fixed word is selected.
  function automatic logic [31:0] memData(input int i);
    return ~reqAddr(i);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got no/unexpected event, expected the scheduled one", name);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pushExpect(input int req, input logic [31:0] data, input logic [1:0] resp);
    exp_t e;
    e.req  = req;
    e.addr = reqAddr(req);
    e.prot = 3'(req);
    e.data = data;
    e.resp = resp;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int req);
    issued[req]++;
  endtask

  task automatic applyReset();
    i_rst = 1'b1;
    sb.delete();
    for (int i = 0; i < NUM_REQ; i++) issued[i] = accepted[i];
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_grant", o_grant, 0);
    checkOutput("rst_arvalid", m_arvalid, 0);
    checkOutput("rst_araddr", m_araddr, 0);
    checkOutput("rst_arprot", m_arprot, 0);
    checkOutput("rst_arready", s_arready, 0);
    checkOutput("rst_rvalid", s_rvalid, 0);
    checkOutput("rst_rready", m_rready, 0);
    checkOutput("rst_rdata", s_rdata, 0);
    i_rst = 1'b0;
    tick();
  endtask

  task automatic waitDone(input int budget, input bit track_gaps);
    int  k = 0;
    int  idle_run = 0;
    bit  seen_busy = 0;
    bit  pending;
    forever begin
      @(negedge i_clk);
      k++;
      if (track_gaps) begin
        if (o_busy) begin
          if (seen_busy && idle_run > 0) checkOutput("busy_gap", idle_run, 1);
          seen_busy = 1;
          idle_run  = 0;
        end else if (seen_busy) begin
          idle_run++;
        end
      end
      pending = 0;
      for (int i = 0; i < NUM_REQ; i++) if (issued[i] > accepted[i]) pending = 1;
      if (sb.size() == 0 && !o_busy && !pending) break;
      if (k >= budget) begin
        failNow("timeout");
        break;
      end
    end
  endtask

  // Requesters: arvalid stays high while they have unaccepted requests.
  initial begin
    logic [NUM_REQ-1:0] acc;
    s_arvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      s_araddr[i*AW +: AW] = reqAddr(i);
      s_arprot[i*3 +: 3]   = 3'(i);
    end
    forever begin
      @(negedge i_clk);
      acc = s_arvalid & s_arready;
      @(posedge i_clk);
      #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i] && !i_rst) accepted[i]++;
        s_arvalid[i] = (issued[i] > accepted[i]);
      end
    end
  end

  // Memory responder with programmable AR and R wait cycles.
  initial begin
    int          phase;
    int          cnt;
    logic        ar_hs;
    logic        r_hs;
    logic [31:0] lat_addr;
    phase = 0; cnt = 0; lat_addr = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
    forever begin
      @(negedge i_clk);
      ar_hs = m_arvalid && m_arready;
      r_hs  = m_rvalid && m_rready;
      if (ar_hs) lat_addr = m_araddr;
      @(posedge i_clk);
      #1;
      if (i_rst) begin
        phase = 0; cnt = 0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
      end else begin
        if (phase == 0) begin
          if (ar_hs) begin
            m_arready = 1'b0;
            phase = 1;
            cnt = 0;
          end else if (m_arvalid) begin
            cnt++;
            m_arready = (cnt > ar_wait);
          end
        end
        if (phase == 1) begin
          if (r_hs) begin
            m_rvalid = 1'b0;
            phase = 0;
            cnt = 0;
          end else if (!m_rvalid) begin
            cnt++;
            if (cnt > r_wait) begin
              m_rvalid = 1'b1;
              m_rdata  = mem_fix ? mem_fix_data : ~lat_addr;
              m_rresp  = mem_resp;
            end
          end
        end
      end
    end
  end

  // Monitor: grants, AR handshakes and R deliveries are checked against the queue front.
  initial begin
    logic        prev_wait;
    logic [31:0] prev_addr;
    logic [2:0]  prev_prot;
    exp_t        e;
    prev_wait = 0; prev_addr = '0; prev_prot = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        prev_wait = 0;
        continue;
      end
      if (s_arready != '0) begin
        checkOutput("arready_onehot", 64'($onehot(s_arready)), 1);
        if (sb.size() == 0) failNow("unexpected_grant");
        else checkOutput("arready_req", s_arready, 64'(1) << sb[0].req);
      end
      if (prev_wait) begin
        checkOutput("ar_hold_valid", m_arvalid, 1);
        checkOutput("ar_hold_addr", m_araddr, prev_addr);
        checkOutput("ar_hold_prot", m_arprot, prev_prot);
      end
      prev_wait = m_arvalid && !m_arready;
      prev_addr = m_araddr;
      prev_prot = m_arprot;
      if (m_arvalid && m_arready) begin
        if (sb.size() == 0) failNow("unexpected_ar");
        else begin
          e = sb[0];
          checkOutput("ar_grant", o_grant, e.req);
          checkOutput("ar_addr", m_araddr, e.addr);
          checkOutput("ar_prot", m_arprot, e.prot);
        end
      end
      if ((s_rvalid & s_rready) != '0) begin
        if (sb.size() == 0) failNow("unexpected_r");
        else begin
          e = sb.pop_front();
          checkOutput("r_valid_vec", s_rvalid, 64'(1) << e.req);
          checkOutput("r_data", s_rdata, e.data);
          checkOutput("r_resp", s_rresp, e.resp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    i_rst = 1'b1;
    s_rready = '1;
    ar_wait = 0; r_wait = 1;
    mem_fix = 1'b1; mem_fix_data = 32'hDEAD_BEEF; mem_resp = 2'b00;
    applyReset();

    // Single request from 3, then probe that rr_ptr moved to 4 (5 beats 2).
    pushExpect(3, 32'hDEAD_BEEF, 2'b00);
    applyStimulus(3);
    @(negedge i_clk);
    checkOutput("t1_arready", s_arready, 16'h0008);
    @(negedge i_clk);
    checkOutput("t1_arvalid", m_arvalid, 1);
    checkOutput("t1_araddr", m_araddr, 32'h1000_0040);
    waitDone(50, 0);
    checkOutput("t1_grant", o_grant, 3);
    mem_fix = 1'b0;
    tick();
    pushExpect(5, memData(5), 2'b00);
    pushExpect(2, memData(2), 2'b00);
    applyStimulus(5);
    applyStimulus(2);
    waitDone(100, 0);

    // All sixteen requesters valid from reset.
    applyReset();
    r_wait = 0;
    for (int i = 0; i < NUM_REQ; i++) pushExpect(i, memData(i), 2'b00);
    pushExpect(0, memData(0), 2'b00);
    pushExpect(1, memData(1), 2'b00);
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i);
    applyStimulus(0);
    applyStimulus(1);
    waitDone(500, 1);

    // Requesters 2 and 5 alternating.
    applyReset();
    pushExpect(2, memData(2), 2'b00);
    pushExpect(5, memData(5), 2'b00);
    pushExpect(2, memData(2), 2'b00);
    pushExpect(5, memData(5), 2'b00);
    applyStimulus(2); applyStimulus(2);
    applyStimulus(5); applyStimulus(5);
    waitDone(200, 0);

    // Backpressure on both AR and R.
    applyReset();
    ar_wait = 10; r_wait = 2;
    s_rready[6] = 1'b0;
    pushExpect(6, memData(6), 2'b00);
    applyStimulus(6);
    k = 0;
    begin
      int n = 0;
      while (!(m_arvalid && m_arready) && k < 100) begin
        @(negedge i_clk);
        if (m_arvalid && !m_arready) n++;
        k++;
      end
      checkOutput("t4_ar_wait_cycles", n, 10);
    end
    k = 0;
    while (!m_rvalid && k < 50) begin
      @(negedge i_clk);
      k++;
    end
    if (!m_rvalid) failNow("t4_no_rvalid");
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge i_clk);
      checkOutput("t4_rready_held", m_rready, 0);
      checkOutput("t4_busy_data", o_busy, 1);
      checkOutput("t4_rvalid_vec", s_rvalid, 16'h0040);
    end
    tick();
    s_rready[6] = 1'b1;
    @(negedge i_clk);
    checkOutput("t4_rready_5th", m_rready, 1);
    @(negedge i_clk);
    checkOutput("t4_idle_after", o_busy, 0);
    waitDone(50, 0);
    ar_wait = 0; r_wait = 0;

    // Error response forwarded.
    tick();
    mem_fix = 1'b1; mem_fix_data = 32'h0; mem_resp = 2'b10;
    pushExpect(7, 32'h0, 2'b10);
    applyStimulus(7);
    waitDone(50, 0);
    mem_fix = 1'b0; mem_resp = 2'b00;

    // Reset in the middle of DATA, then rr_ptr must be back at 0.
    tick();
    pushExpect(12, memData(12), 2'b00);
    applyStimulus(12);
    waitDone(50, 0);
    tick();
    r_wait = 8;
    pushExpect(14, memData(14), 2'b00);
    applyStimulus(14);
    k = 0;
    while (!m_rready && k < 50) begin
      @(negedge i_clk);
      k++;
    end
    if (!m_rready) failNow("t6_no_data_state");
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("t6_arvalid", m_arvalid, 0);
    checkOutput("t6_rready", m_rready, 0);
    checkOutput("t6_rvalid", s_rvalid, 0);
    checkOutput("t6_busy", o_busy, 0);
    applyReset();
    r_wait = 0;
    pushExpect(9, memData(9), 2'b00);
    pushExpect(15, memData(15), 2'b00);
    applyStimulus(9);
    applyStimulus(15);
    waitDone(100, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
